// File: rtl/ariane_pkg.sv
// Core package slice: the scoreboard entry carried from decode to issue.
package ariane_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  trans_id;
      logic [3:0]  fu;
      logic [7:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] result;
      logic        valid;
      logic        use_imm;
   } scoreboard_entry_t;

endpackage

// File: rtl/config_pkg.sv
// Core configuration slice: only the configuration record type and the
// empty default configuration are needed by the decode/issue buffer.
package config_pkg;

   typedef struct packed {
      logic [31:0] XLEN;
      logic [31:0] VLEN;
      logic        RVF;
      logic        RVC;
      logic        DebugEn;
      logic [7:0]  NrCommitPorts;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/decode_issue_fifo.sv
// Decode-to-issue buffer. Holds up to DEPTH decoded instructions and offers
// the oldest to the issue stage. After a control-flow instruction is issued,
// further issue is held off until execute resolves that branch.
module decode_issue_fifo
   import ariane_pkg::*;
#(
   parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
   parameter int unsigned           DEPTH   = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   input  logic                      stall_i,
   input  scoreboard_entry_t         decoded_instr_i,
   input  logic                      decoded_instr_valid_i,
   input  logic                      is_ctrl_flow_i,
   output logic                      decoded_instr_ready_o,
   output scoreboard_entry_t         issue_instr_o,
   output logic                      issue_instr_valid_o,
   output logic                      issue_is_ctrl_flow_o,
   input  logic                      issue_ack_i,
   input  logic                      resolve_branch_i,
   output logic [$clog2(DEPTH):0]    fill_level_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] FullLvl = (PtrW + 1)'(DEPTH);

   typedef enum logic {
      IDLE,
      WAIT_BRANCH
   } state_e;

   typedef struct packed {
      scoreboard_entry_t instr;
      logic              ctrl_flow;
   } slot_t;

   slot_t          r_mem [DEPTH];
   logic [PtrW-1:0] r_rd_ptr;
   logic [PtrW-1:0] r_wr_ptr;
   logic [PtrW:0]   r_fill;
   state_e          r_state;

   logic w_ready;
   logic w_valid;
   logic w_push;
   logic w_pop;
   logic w_unused_cfg;

   assign w_unused_cfg = ^CVA6Cfg;

   // Handshake qualifiers; ready depends only on fill level and flush so
   // there is no combinational path from issue_ack_i.
   always_comb begin
      w_ready = (r_fill != FullLvl) && !flush_i;
      w_valid = (r_fill != '0) && !stall_i && (r_state == IDLE) && !flush_i;
      w_push  = decoded_instr_valid_i && w_ready;
      w_pop   = w_valid && issue_ack_i;
   end

   // Output drive: head entry comes straight from storage.
   always_comb begin
      decoded_instr_ready_o = w_ready;
      issue_instr_valid_o   = w_valid;
      issue_instr_o         = r_mem[r_rd_ptr].instr;
      issue_is_ctrl_flow_o  = r_mem[r_rd_ptr].ctrl_flow;
      fill_level_o          = r_fill;
   end

   // Entry storage: written only on an accepted push.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= '{instr: decoded_instr_i, ctrl_flow: is_ctrl_flow_i};
      end
   end

   // Pointers and fill level; flush discards everything buffered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_fill   <= '0;
      end else if (flush_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   // Branch gate: issuing a control-flow entry blocks issue until resolve.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else if (flush_i) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop && r_mem[r_rd_ptr].ctrl_flow) begin
                  r_state <= WAIT_BRANCH;
               end
            end
            WAIT_BRANCH: begin
               if (resolve_branch_i) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decode_issue_fifo.sv
// Directed bench for decode_issue_fifo: a table of per-cycle vectors plus
// hand-written sequences for wrap-around, flush, stall and mid-stream reset.
module tb_decode_issue_fifo;
   import ariane_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              flush;
   logic              stall;
   scoreboard_entry_t din;
   logic              dvalid;
   logic              cflow;
   logic              ready;
   scoreboard_entry_t dout;
   logic              ivalid;
   logic              icf;
   logic              ack;
   logic              resolve;
   logic [2:0]        level;

   int n_cmp = 0;
   int n_bad = 0;

   decode_issue_fifo #(.DEPTH(DEPTH)) dut (
      .clk_i                 (clk),
      .rst_ni                (rst_n),
      .flush_i               (flush),
      .stall_i               (stall),
      .decoded_instr_i       (din),
      .decoded_instr_valid_i (dvalid),
      .is_ctrl_flow_i        (cflow),
      .decoded_instr_ready_o (ready),
      .issue_instr_o         (dout),
      .issue_instr_valid_o   (ivalid),
      .issue_is_ctrl_flow_o  (icf),
      .issue_ack_i           (ack),
      .resolve_branch_i      (resolve),
      .fill_level_o          (level)
   );

   typedef struct {
      logic push;
      int   tag;
      logic cf;
      logic ack;
      logic stall;
      logic flush;
      logic res;
      logic rdy;
      logic vld;
      logic ecf;
      int   etag;
      int   lvl;
   } vec_t;

   vec_t tbl[$];

   function automatic scoreboard_entry_t mk(input int tag);
      scoreboard_entry_t e;
      e          = '0;
      e.pc       = 32'h8000_0000 + 32'(tag) * 32'd4;
      e.trans_id = 3'(tag);
      e.rd       = 5'(tag);
      e.result   = ~e.pc;
      e.valid    = 1'b1;
      return e;
   endfunction

   function automatic vec_t V(input logic p, input int tag, input logic cf, input logic a,
                              input logic st, input logic fl, input logic rs,
                              input logic rdy, input logic vld, input logic ecf,
                              input int etag, input int lvl);
      vec_t v;
      v.push = p; v.tag = tag; v.cf = cf; v.ack = a; v.stall = st; v.flush = fl; v.res = rs;
      v.rdy = rdy; v.vld = vld; v.ecf = ecf; v.etag = etag; v.lvl = lvl;
      return v;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One cycle: drive inputs at the falling edge, check just after, then clock.
   task automatic cyc(input string nm, input vec_t v);
      dvalid  = v.push;
      din     = mk(v.tag);
      cflow   = v.cf;
      ack     = v.ack;
      stall   = v.stall;
      flush   = v.flush;
      resolve = v.res;
      #1;
      chk({nm, ".ready"}, longint'(ready), longint'(v.rdy));
      chk({nm, ".valid"}, longint'(ivalid), longint'(v.vld));
      chk({nm, ".level"}, longint'(level), longint'(v.lvl));
      if (v.etag >= 0) begin
         chk({nm, ".head_pc"}, longint'(dout.pc), longint'(mk(v.etag).pc));
         chk({nm, ".head_cf"}, longint'(icf), longint'(v.ecf));
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; stall = 1'b0; dvalid = 1'b0; cflow = 1'b0;
      ack = 1'b0; resolve = 1'b0; din = '0;

      // fill to full, refused push (also with a same-cycle pop), in-order drain
      tbl.push_back(V(1, 1, 0, 0, 0, 0, 0,  1, 0, 0, -1, 0));
      tbl.push_back(V(1, 2, 0, 0, 0, 0, 0,  1, 1, 0,  1, 1));
      tbl.push_back(V(1, 3, 0, 0, 0, 0, 0,  1, 1, 0,  1, 2));
      tbl.push_back(V(1, 4, 0, 0, 0, 0, 0,  1, 1, 0,  1, 3));
      tbl.push_back(V(1, 5, 0, 0, 0, 0, 0,  0, 1, 0,  1, 4));
      tbl.push_back(V(1, 5, 0, 1, 0, 0, 0,  0, 1, 0,  1, 4));
      tbl.push_back(V(0, 0, 0, 1, 0, 0, 0,  1, 1, 0,  2, 3));
      tbl.push_back(V(0, 0, 0, 1, 0, 0, 0,  1, 1, 0,  3, 2));
      tbl.push_back(V(0, 0, 0, 1, 0, 0, 0,  1, 1, 0,  4, 1));
      tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, -1, 0));
      // control-flow gate
      tbl.push_back(V(1, 6, 1, 0, 0, 0, 0,  1, 0, 0, -1, 0));
      tbl.push_back(V(1, 7, 0, 0, 0, 0, 0,  1, 1, 1,  6, 1));
      tbl.push_back(V(0, 0, 0, 1, 0, 0, 0,  1, 1, 1,  6, 2));
      tbl.push_back(V(0, 0, 0, 1, 0, 0, 0,  1, 0, 0,  7, 1));
      tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  1, 0, 0,  7, 1));
      tbl.push_back(V(0, 0, 0, 0, 0, 0, 1,  1, 0, 0,  7, 1));
      tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  1, 1, 0,  7, 1));
      tbl.push_back(V(0, 0, 0, 1, 0, 0, 0,  1, 1, 0,  7, 1));
      // simultaneous push/pop at level 2
      tbl.push_back(V(1, 8, 0, 0, 0, 0, 0,  1, 0, 0, -1, 0));
      tbl.push_back(V(1, 9, 0, 0, 0, 0, 0,  1, 1, 0,  8, 1));
      tbl.push_back(V(1, 10, 0, 1, 0, 0, 0, 1, 1, 0,  8, 2));
      tbl.push_back(V(1, 11, 0, 1, 0, 0, 0, 1, 1, 0,  9, 2));
      tbl.push_back(V(0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 10, 2));
      tbl.push_back(V(0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 11, 1));
      tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, -1, 0));

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk("reset.ready", longint'(ready), 1);
      chk("reset.valid", longint'(ivalid), 0);
      chk("reset.cf", longint'(icf), 0);
      chk("reset.instr_zero", longint'(dout == '0), 1);
      chk("reset.level", longint'(level), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         cyc($sformatf("vec%0d", i), tbl[i]);
      end

      // wrap-around: 10 entries streamed at level 3, order preserved
      for (int c = 0; c < 3; c++)
         cyc($sformatf("wrap_fill%0d", c),
             V(1, 20 + c, 0, 0, 0, 0, 0, 1, c > 0, 0, (c > 0) ? 20 : -1, c));
      for (int c = 3; c < 10; c++)
         cyc($sformatf("wrap_stream%0d", c),
             V(1, 20 + c, 0, 1, 0, 0, 0, 1, 1, 0, 20 + c - 3, 3));
      for (int k = 0; k < 3; k++)
         cyc($sformatf("wrap_drain%0d", k),
             V(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 27 + k, 3 - k));
      cyc("wrap_empty", V(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, -1, 0));

      // flush at level 3 in WAIT_BRANCH with concurrent push and resolve
      cyc("fl_a", V(1, 30, 1, 0, 0, 0, 0, 1, 0, 0, -1, 0));
      cyc("fl_b", V(1, 31, 0, 0, 0, 0, 0, 1, 1, 1, 30, 1));
      cyc("fl_c", V(1, 32, 0, 1, 0, 0, 0, 1, 1, 1, 30, 2));
      cyc("fl_d", V(1, 33, 0, 0, 0, 0, 0, 1, 0, 0, 31, 2));
      cyc("fl_flush", V(1, 34, 0, 1, 0, 1, 1, 0, 0, 0, 31, 3));
      cyc("fl_after", V(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, -1, 0));
      cyc("fl_push", V(1, 35, 0, 0, 0, 0, 0, 1, 0, 0, -1, 0));
      cyc("fl_idle", V(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 35, 1));
      cyc("fl_empty", V(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, -1, 0));

      // stall with ack held: no pop, head unchanged after release
      cyc("st_a", V(1, 40, 0, 0, 0, 0, 0, 1, 0, 0, -1, 0));
      cyc("st_b", V(1, 41, 0, 0, 0, 0, 0, 1, 1, 0, 40, 1));
      cyc("st_hold0", V(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 40, 2));
      cyc("st_hold1", V(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 40, 2));
      cyc("st_rel0", V(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 40, 2));
      cyc("st_rel1", V(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 41, 1));
      cyc("st_empty", V(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, -1, 0));

      // reset asserted mid-stream at level 3
      cyc("rs_a", V(1, 50, 0, 0, 0, 0, 0, 1, 0, 0, -1, 0));
      cyc("rs_b", V(1, 51, 0, 0, 0, 0, 0, 1, 1, 0, 50, 1));
      cyc("rs_c", V(1, 52, 1, 0, 0, 0, 0, 1, 1, 0, 50, 2));
      dvalid = 1'b0; ack = 1'b0; din = '0;
      #1;
      chk("rs_pre.level", longint'(level), 3);
      rst_n = 1'b0;
      #1;
      chk("rs_in.ready", longint'(ready), 1);
      chk("rs_in.valid", longint'(ivalid), 0);
      chk("rs_in.cf", longint'(icf), 0);
      chk("rs_in.instr_zero", longint'(dout == '0), 1);
      chk("rs_in.level", longint'(level), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc("rs_post", V(1, 60, 0, 0, 0, 0, 0, 1, 0, 0, -1, 0));
      cyc("rs_head", V(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 60, 1));
      cyc("rs_empty", V(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, -1, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
